// File: rtl/tm_shiftreg_ctrl_if.sv
// tm_shiftreg_ctrl_if: config-word, strobe and serial-pin bundle
// between the TM shift-register sequencer and its surroundings.
interface tm_shiftreg_ctrl_if #(
  parameter int DATA_WIDTH = 170,
  parameter int DIV_WIDTH  = 8
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  start;
  logic [DIV_WIDTH-1:0]  div;
  logic                  sout;
  logic                  sin;
  logic                  sclk;
  logic                  load;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;

  modport master (
    output data_in, start, div, sout,
    input  sin, sclk, load, data_out, busy, done
  );

  modport slave (
    input  data_in, start, div, sout,
    output sin, sclk, load, data_out, busy, done
  );

endinterface

// File: rtl/tm_shiftreg_ctrl.sv
// tm_shiftreg_ctrl: shifts a config word MSB-first into the TM shift
// register on a divided clock, strobes load, and captures readback.
module tm_shiftreg_ctrl #(
  parameter int DATA_WIDTH = 170,
  parameter int CNT_WIDTH  = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  tm_shiftreg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BIT =
    CNT_WIDTH'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] tx_reg;
  logic [DATA_WIDTH-1:0] tx_nxt;
  logic [DATA_WIDTH-1:0] rx_reg;
  logic [DATA_WIDTH-1:0] rx_nxt;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic [DIV_WIDTH-1:0]  div_reg;
  logic [DIV_WIDTH-1:0]  div_nxt;
  logic [DIV_WIDTH-1:0]  phase_cnt;
  logic [DIV_WIDTH-1:0]  phase_nxt;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CNT_WIDTH-1:0]  bit_nxt;
  logic                  phase_end;

  logic sin_q, sclk_q, load_q, busy_q, done_q;
  logic sin_nxt, sclk_nxt, load_nxt, busy_nxt, done_nxt;

  assign phase_end = (phase_cnt == div_reg);

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx_reg;
    rx_nxt    = rx_reg;
    dout_nxt  = dout_q;
    div_nxt   = div_reg;
    bit_nxt   = bit_cnt;
    phase_nxt = phase_cnt + DIV_WIDTH'(1);
    unique case (state)
      IDLE: begin
        phase_nxt = '0;
        if (bus.start) begin
          tx_nxt    = bus.data_in;
          div_nxt   = bus.div;
          bit_nxt   = '0;
          rx_nxt    = '0;
          state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          phase_nxt = '0;
          state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (phase_end) begin
          phase_nxt = '0;
          rx_nxt    = {rx_reg[DATA_WIDTH-2:0], bus.sout};
          tx_nxt    = {tx_reg[DATA_WIDTH-2:0], 1'b0};
          bit_nxt   = bit_cnt + CNT_WIDTH'(1);
          state_nxt = (bit_cnt == LAST_BIT) ? LOAD : SHIFT_LO;
        end
      end
      LOAD: begin
        if (phase_end) begin
          phase_nxt = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        phase_nxt = '0;
        dout_nxt  = rx_reg;
        state_nxt = IDLE;
      end
      default: begin
        phase_nxt = '0;
        state_nxt = IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they are registered
    // and valid in the first cycle of each state.
    sclk_nxt = (state_nxt == SHIFT_HI);
    load_nxt = (state_nxt == LOAD);
    done_nxt = (state_nxt == DONE);
    busy_nxt = (state_nxt != IDLE);
    sin_nxt  = (state_nxt == SHIFT_LO || state_nxt == SHIFT_HI)
               && tx_nxt[DATA_WIDTH-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      tx_reg    <= '0;
      rx_reg    <= '0;
      dout_q    <= '0;
      div_reg   <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      sin_q     <= 1'b0;
      sclk_q    <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_reg    <= tx_nxt;
      rx_reg    <= rx_nxt;
      dout_q    <= dout_nxt;
      div_reg   <= div_nxt;
      bit_cnt   <= bit_nxt;
      phase_cnt <= phase_nxt;
      sin_q     <= sin_nxt;
      sclk_q    <= sclk_nxt;
      load_q    <= load_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.sin      = sin_q;
  assign bus.sclk     = sclk_q;
  assign bus.load     = load_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = dout_q;

endmodule

// File: tb/tb_tm_shiftreg_ctrl.sv
// tb_tm_shiftreg_ctrl: 8-bit and 170-bit sequencers against a
// cycle-index reference model and a loopback shift-register model.
module tb_tm_shiftreg_ctrl;

  localparam int MW = 170;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [MW-1:0] din [2];
  logic [7:0]    dv  [2];
  logic          st  [2];

  logic [MW-1:0] lb        [2] = '{default: '0};
  logic          hold      [2] = '{default: 1'b0};
  logic          prev_sclk [2] = '{default: 1'b0};
  logic [MW-1:0] pl_val    [2] = '{default: '0};
  int            pl_seq    [2] = '{default: 0};
  int            pl_ack    [2] = '{default: 0};

  logic          o_sin  [2];
  logic          o_sclk [2];
  logic          o_load [2];
  logic          o_busy [2];
  logic          o_done [2];
  logic [MW-1:0] o_dout [2];

  int act [2] = '{default: 0};
  int c   [2] = '{default: 0};
  int d   [2] = '{default: 0};
  logic [MW-1:0] mdata [2] = '{default: '0};
  logic [MW-1:0] snap  [2] = '{default: '0};
  logic [MW-1:0] edout [2] = '{default: '0};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  tm_shiftreg_ctrl_if #(.DATA_WIDTH(8),  .DIV_WIDTH(8)) b0 ();
  tm_shiftreg_ctrl_if #(.DATA_WIDTH(MW), .DIV_WIDTH(8)) b1 ();

  assign b0.data_in = din[0][7:0];
  assign b0.div     = dv[0];
  assign b0.start   = st[0];
  assign b0.sout    = lb[0][7];
  assign b1.data_in = din[1];
  assign b1.div     = dv[1];
  assign b1.start   = st[1];
  assign b1.sout    = lb[1][MW-1];

  assign o_sin[0]  = b0.sin;
  assign o_sclk[0] = b0.sclk;
  assign o_load[0] = b0.load;
  assign o_busy[0] = b0.busy;
  assign o_done[0] = b0.done;
  assign o_dout[0] = {{(MW-8){1'b0}}, b0.data_out};
  assign o_sin[1]  = b1.sin;
  assign o_sclk[1] = b1.sclk;
  assign o_load[1] = b1.load;
  assign o_busy[1] = b1.busy;
  assign o_done[1] = b1.done;
  assign o_dout[1] = b1.data_out;

  tm_shiftreg_ctrl #(
    .DATA_WIDTH(8), .CNT_WIDTH(8), .DIV_WIDTH(8)
  ) u0 (
    .clk_in(clk_in), .rst(rst), .bus(b0)
  );

  tm_shiftreg_ctrl #(
    .DATA_WIDTH(MW), .CNT_WIDTH(8), .DIV_WIDTH(8)
  ) u1 (
    .clk_in(clk_in), .rst(rst), .bus(b1)
  );

  function automatic int wd(input int i);
    return (i == 0) ? 8 : MW;
  endfunction

  function automatic logic [MW-1:0] wmask(input int i);
    logic [MW-1:0] m;
    m = '1;
    if (i == 0) m = {{(MW-8){1'b0}}, 8'hFF};
    return m;
  endfunction

  function automatic int tend(input int i);
    return 1 + (2 * wd(i) + 1) * (d[i] + 1);
  endfunction

  task automatic chk(input string nm, input logic [MW-1:0] got,
                     input logic [MW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Reference model: cycle index within the current transfer.
  always @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i]   = 0;
        c[i]     = 0;
        edout[i] = '0;
      end else if (act[i] != 0) begin
        if (c[i] == tend(i)) begin
          act[i]   = 0;
          edout[i] = snap[i];
        end else begin
          c[i]++;
        end
      end else if (st[i]) begin
        act[i]   = 1;
        c[i]     = 1;
        d[i]     = int'(dv[i]);
        mdata[i] = din[i] & wmask(i);
        snap[i]  = lb[i] & wmask(i);
      end
    end
  end

  // Loopback register (shifts on sclk fall) and per-cycle compare.
  always @(negedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      int   p;
      int   idx;
      logic e_sin, e_sclk, e_load, e_busy, e_done;
      if (pl_seq[i] != pl_ack[i]) begin
        lb[i]     = pl_val[i] & wmask(i);
        pl_ack[i] = pl_seq[i];
      end else if (prev_sclk[i] === 1'b1 && o_sclk[i] === 1'b0) begin
        lb[i] = ((lb[i] << 1) | MW'(hold[i])) & wmask(i);
      end
      if (o_sclk[i] === 1'b1) hold[i] = o_sin[i];
      prev_sclk[i] = o_sclk[i];

      if (chk_en) begin
        e_sin = 1'b0; e_sclk = 1'b0; e_load = 1'b0;
        e_busy = 1'b0; e_done = 1'b0;
        if (act[i] != 0) begin
          p      = d[i] + 1;
          e_busy = 1'b1;
          if (c[i] < 1 + 2 * wd(i) * p) begin
            idx    = (c[i] - 1) / p;
            e_sclk = (idx % 2) == 1;
            e_sin  = mdata[i][wd(i) - 1 - idx / 2];
          end else if (c[i] < tend(i)) begin
            e_load = 1'b1;
          end else begin
            e_done = 1'b1;
          end
        end
        chk($sformatf("u%0d.sclk", i), MW'(o_sclk[i]), MW'(e_sclk));
        chk($sformatf("u%0d.sin", i),  MW'(o_sin[i]),  MW'(e_sin));
        chk($sformatf("u%0d.load", i), MW'(o_load[i]), MW'(e_load));
        chk($sformatf("u%0d.busy", i), MW'(o_busy[i]), MW'(e_busy));
        chk($sformatf("u%0d.done", i), MW'(o_done[i]), MW'(e_done));
        chk($sformatf("u%0d.data_out", i), o_dout[i], edout[i]);
      end
    end
  end

  task automatic preload(input int i, input logic [MW-1:0] v);
    pl_val[i] = v;
    pl_seq[i] = pl_seq[i] + 1;
    repeat (2) @(negedge clk_in);
  endtask

  // Start pulse in cycle 0; returns at the negedge of the done cycle.
  task automatic xfer(input int i, input logic [MW-1:0] data,
                      input logic [7:0] dvv, input int glitch,
                      output int t_done, output int t_load,
                      output int t_busy, output logic [7:0] sinb);
    int p;
    p = int'(dvv) + 1;
    t_done = -1; t_load = -1; t_busy = -1; sinb = '0;
    @(posedge clk_in); #1;
    din[i] = data; dv[i] = dvv; st[i] = 1'b1;
    for (int n = 1; n <= 4000 && t_done < 0; n++) begin
      @(posedge clk_in); #1;
      st[i] = (n == glitch);
      if (n == glitch) begin
        din[i] = ~data;
        dv[i]  = dvv + 8'd2;
      end
      @(negedge clk_in);
      if (o_busy[i] && t_busy < 0) t_busy = n;
      if (o_load[i] && t_load < 0) t_load = n;
      if ((n - 1) % (2 * p) == 0 && (n - 1) / (2 * p) < 8)
        sinb[7 - (n - 1) / (2 * p)] = o_sin[i];
      if (o_done[i]) t_done = n;
    end
    st[i] = 1'b0;
  endtask

  function automatic logic [MW-1:0] rnd();
    logic [MW-1:0] r;
    for (int k = 0; k < MW; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    int            td, tl, tbz, nd;
    logic [7:0]    sb;
    logic [MW-1:0] r, r2, p55;
    p55 = {85{2'b01}};
    st  = '{default: 1'b0};
    din = '{default: '0};
    dv  = '{default: 8'd0};

    @(posedge clk_in); #1;
    chk_en = 1'b1;
    @(negedge clk_in);
    chk("rst.busy",     MW'(b1.busy), '0);
    chk("rst.sclk",     MW'(b1.sclk), '0);
    chk("rst.data_out", b1.data_out,  '0);
    @(posedge clk_in); #1;
    rst = 1'b0;

    repeat (1000) @(posedge clk_in);
    @(negedge clk_in);
    chk("idle.data_out", b1.data_out, '0);
    chk("idle.busy",     MW'(b0.busy), '0);

    preload(0, MW'(8'h3C));
    xfer(0, MW'(8'hA5), 8'd0, 0, td, tl, tbz, sb);
    chk_i("a5.done_cyc", td, 18);
    chk_i("a5.load_cyc", tl, 17);
    chk("a5.sin_seq", MW'(sb), MW'(8'hA5));
    @(negedge clk_in);
    chk("a5.data_out", MW'(b0.data_out), MW'(8'h3C));
    chk("a5.model", lb[0], MW'(8'hA5));

    xfer(0, MW'(8'h69), 8'd3, 0, td, tl, tbz, sb);
    chk_i("div3.done_cyc", td, 69);
    chk_i("div3.load_cyc", tl, 65);
    @(negedge clk_in);
    chk("div3.model", lb[0], MW'(8'h69));

    preload(1, p55);
    r = rnd();
    xfer(1, r, 8'd0, 0, td, tl, tbz, sb);
    chk_i("w170.done_cyc", td, 342);
    @(negedge clk_in);
    chk("w170.data_out", b1.data_out, p55);
    chk("w170.model", lb[1], r);

    r2 = rnd();
    xfer(1, r2, 8'd0, 5, td, tl, tbz, sb);
    chk_i("glitch.done_cyc", td, 342);
    nd = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (b1.done) nd++;
    end
    chk_i("glitch.extra_done", nd, 0);
    chk("glitch.model", lb[1], r2);

    r = rnd();
    xfer(1, r, 8'd0, 0, td, tl, tbz, sb);
    r2 = rnd();
    xfer(1, r2, 8'd0, 0, td, tl, tbz, sb);
    chk_i("b2b.first_busy", tbz, 1);
    chk_i("b2b.done_cyc", td, 342);
    @(negedge clk_in);
    chk("b2b.data_out", b1.data_out, r);

    preload(1, p55);
    xfer(1, rnd(), 8'd0, 0, td, tl, tbz, sb);
    @(negedge clk_in);
    chk("prerst.data_out", b1.data_out, p55);
    @(posedge clk_in); #1;
    din[1] = rnd(); dv[1] = 8'd0; st[1] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_in); #1;
      st[1] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    @(negedge clk_in);
    chk("midrst.busy",     MW'(b1.busy), '0);
    chk("midrst.sclk",     MW'(b1.sclk), '0);
    chk("midrst.sin",      MW'(b1.sin),  '0);
    chk("midrst.load",     MW'(b1.load), '0);
    chk("midrst.done",     MW'(b1.done), '0);
    chk("midrst.data_out", b1.data_out,  '0);
    repeat (5) @(negedge clk_in);

    r = rnd();
    xfer(1, r, 8'd0, 0, td, tl, tbz, sb);
    chk_i("postrst.done_cyc", td, 342);
    @(negedge clk_in);
    chk("postrst.model", lb[1], r);

    repeat (5) @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
